// File: rtl/smol_pkg.sv
// Shared definitions for smol SoC bus peripherals: register offsets and the
// bus request bundle used by the address decoders.
package smol_pkg;
  localparam int SMOL_AW = 24;

  localparam logic [2:0] OFS_IN      = 3'd0;
  localparam logic [2:0] OFS_OUT     = 3'd1;
  localparam logic [2:0] OFS_OE      = 3'd2;
  localparam logic [2:0] OFS_RISE    = 3'd3;
  localparam logic [2:0] OFS_FALL    = 3'd4;
  localparam logic [2:0] OFS_IE_RISE = 3'd5;
  localparam logic [2:0] OFS_IE_FALL = 3'd6;

  typedef struct packed {
    logic               valid;
    logic               write;
    logic [SMOL_AW-1:0] addr;
    logic [7:0]         wdata;
  } bus_req_t;
endpackage

// File: rtl/smol_gpio_port.sv
// One 8-bit GPIO port: pin synchroniser, edge history, OUT/OE/IE registers,
// sticky edge flags and this port's interrupt term.
module smol_gpio_port
  import smol_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] pin_i,
  input  logic       armed,
  input  logic       we,
  input  logic [2:0] ofs,
  input  logic [7:0] wdata,
  output logic [7:0] in_o,
  output logic [7:0] out_o,
  output logic [7:0] oe_o,
  output logic [7:0] rise_o,
  output logic [7:0] fall_o,
  output logic [7:0] ie_rise_o,
  output logic [7:0] ie_fall_o,
  output logic       irq_o
);
  logic [SYNC-1:0][7:0] sync_q, sync_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] out_q, out_d, oe_q, oe_d;
  logic [7:0] rise_q, rise_d, fall_q, fall_d;
  logic [7:0] ier_q, ier_d, ief_q, ief_d;
  logic [7:0] in_v, rise_ev, fall_ev, clr_r, clr_f;

  always_comb begin
    sync_d  = {sync_q[SYNC-2:0], pin_i};
    in_v    = sync_q[SYNC-1];
    prev_d  = in_v;
    rise_ev = armed ? (in_v & ~prev_q) : 8'h00;
    fall_ev = armed ? (~in_v & prev_q) : 8'h00;
    clr_r   = (we && ofs == OFS_RISE) ? wdata : 8'h00;
    clr_f   = (we && ofs == OFS_FALL) ? wdata : 8'h00;
    // new edges are OR'd in after the clear so a coincident edge survives
    rise_d  = (rise_q & ~clr_r) | rise_ev;
    fall_d  = (fall_q & ~clr_f) | fall_ev;
    out_d   = (we && ofs == OFS_OUT)     ? wdata : out_q;
    oe_d    = (we && ofs == OFS_OE)      ? wdata : oe_q;
    ier_d   = (we && ofs == OFS_IE_RISE) ? wdata : ier_q;
    ief_d   = (we && ofs == OFS_IE_FALL) ? wdata : ief_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
      prev_q <= '0;
      out_q  <= '0;
      oe_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      ier_q  <= '0;
      ief_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      out_q  <= out_d;
      oe_q   <= oe_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      ier_q  <= ier_d;
      ief_q  <= ief_d;
    end
  end

  assign in_o      = in_v;
  assign out_o     = out_q;
  assign oe_o      = oe_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign ie_rise_o = ier_q;
  assign ie_fall_o = ief_q;
  assign irq_o     = |((rise_q & ier_q) | (fall_q & ief_q));
endmodule

// File: rtl/smol_gpio.sv
// NPORT-port GPIO on the smol four-phase valid/ready bus: window decode,
// handshake, read mux, post-reset arm counter and the shared irq.
module smol_gpio
  import smol_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int BASE  = 'h2100,
  parameter int AW    = 24,
  parameter int SYNC  = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 valid,
  input  logic                 write,
  input  logic [AW-1:0]        addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 ready,
  input  logic [8*NPORT-1:0]   pin_i,
  output logic [8*NPORT-1:0]   pin_o,
  output logic [8*NPORT-1:0]   pin_oe,
  output logic                 irq
);
  localparam logic [AW:0] LO  = (AW+1)'(BASE);
  localparam logic [AW:0] HI  = LO + (AW+1)'(8*NPORT);
  localparam int          AMW = ($clog2(SYNC+2) > 3) ? $clog2(SYNC+2) : 3;
  localparam logic [AMW-1:0] ARM_N = AMW'(SYNC+1);

  logic            ready_q, ready_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [AMW-1:0]  arm_q, arm_d;
  logic            hit, acc, armed;
  logic [AW-1:0]   off;
  logic [3:0]      pidx;
  logic [7:0]      rsel;

  logic [NPORT-1:0][7:0] in_a, out_a, oe_a, rise_a, fall_a, ier_a, ief_a;
  logic [NPORT-1:0]      we_a, irq_a;

  assign hit   = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  assign acc   = valid & hit & ~ready_q;
  assign off   = addr - LO[AW-1:0];
  assign pidx  = 4'(off >> 3);
  // block stays blind until the synchroniser and PREV hold real pin levels
  assign armed = (arm_q == ARM_N);

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : gen_port
      assign we_a[gi] = acc & write & (pidx == 4'(gi));
      smol_gpio_port #(.SYNC(SYNC)) u_port (
        .clk       (clk),
        .rstb      (rstb),
        .pin_i     (pin_i[8*gi +: 8]),
        .armed     (armed),
        .we        (we_a[gi]),
        .ofs       (addr[2:0]),
        .wdata     (wdata),
        .in_o      (in_a[gi]),
        .out_o     (out_a[gi]),
        .oe_o      (oe_a[gi]),
        .rise_o    (rise_a[gi]),
        .fall_o    (fall_a[gi]),
        .ie_rise_o (ier_a[gi]),
        .ie_fall_o (ief_a[gi]),
        .irq_o     (irq_a[gi])
      );
      assign pin_o[8*gi +: 8]  = out_a[gi];
      assign pin_oe[8*gi +: 8] = oe_a[gi];
    end
  endgenerate

  always_comb begin
    rsel = 8'h00;
    for (int i = 0; i < NPORT; i++) begin
      if (pidx == 4'(i)) begin
        case (addr[2:0])
          OFS_IN:      rsel = in_a[i];
          OFS_OUT:     rsel = out_a[i];
          OFS_OE:      rsel = oe_a[i];
          OFS_RISE:    rsel = rise_a[i];
          OFS_FALL:    rsel = fall_a[i];
          OFS_IE_RISE: rsel = ier_a[i];
          OFS_IE_FALL: rsel = ief_a[i];
          default:     rsel = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    ready_d = valid & (hit | ready_q);
    rdata_d = rdata_q;
    // a missed request clears rdata; only hit reads load it
    if (valid && !ready_q) rdata_d = (hit && !write) ? rsel : 8'h00;
    arm_d = armed ? arm_q : arm_q + AMW'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_q <= 1'b0;
      rdata_q <= 8'h00;
      arm_q   <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = |irq_a;
endmodule

// File: tb/tb_smol_gpio.sv
// Randomised scoreboard bench for smol_gpio against a register-level model.
module tb_smol_gpio;
  localparam int NPORT = 2;
  localparam int SYNC  = 2;
  localparam int BASE  = 'h2100;

  logic clk = 0, rstb = 0, valid = 0, write = 0;
  logic [23:0] addr = 0;
  logic [7:0]  wdata = 0;
  logic [7:0]  rdata;
  logic        ready, irq;
  logic [8*NPORT-1:0] pin_i = 16'h00FF, pin_o, pin_oe;

  smol_gpio #(.NPORT(NPORT), .BASE(BASE), .AW(24), .SYNC(SYNC)) dut (
    .clk(clk), .rstb(rstb), .valid(valid), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .pin_i(pin_i),
    .pin_o(pin_o), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [NPORT-1:0][7:0] m_out, m_oe, m_rise, m_fall, m_ier, m_ief;
  logic [7:0] exp_q[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_ier = '0; m_ief = '0;
  endtask

  function automatic logic [7:0] m_read(input int p, input int o);
    case (o)
      0: return pin_i[8*p +: 8];
      1: return m_out[p];
      2: return m_oe[p];
      3: return m_rise[p];
      4: return m_fall[p];
      5: return m_ier[p];
      6: return m_ief[p];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_irq();
    return |((m_rise & m_ier) | (m_fall & m_ief));
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_pin_o"}, pin_o, m_out);
    chk({tag, "_pin_oe"}, pin_oe, m_oe);
    chk({tag, "_irq"}, irq, m_irq());
  endtask

  // one full four-phase transfer; reads push their expected data
  task automatic access(input logic [23:0] a, input logic wr, input logic [7:0] d);
    int n, p, o;
    logic hit;
    hit = (a >= BASE) && (a < BASE + 8*NPORT);
    p = (int'(a) - BASE) >>> 3;
    o = int'(a[2:0]);
    @(posedge clk); #1;
    valid = 1; write = wr; addr = a; wdata = d;
    if (hit && !wr) exp_q.push_back(m_read(p, o));
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 8) begin @(posedge clk); #1; n++; end
    if (hit) begin
      chk("ready_rise", ready, 1);
      if (wr) case (o)
        1: m_out[p] = d;
        2: m_oe[p] = d;
        3: m_rise[p] = m_rise[p] & ~d;
        4: m_fall[p] = m_fall[p] & ~d;
        5: m_ier[p] = d;
        6: m_ief[p] = d;
        default: ;
      endcase
    end else begin
      chk("miss_ready", ready, 0);
      chk("miss_rdata", rdata, 0);
    end
    valid = 0;
    @(posedge clk); #1;
    chk("ready_fall", ready, 0);
  endtask

  task automatic set_pins(input logic [8*NPORT-1:0] nv);
    logic [8*NPORT-1:0] ov;
    @(posedge clk); #1;
    ov = pin_i;
    pin_i = nv;
    m_rise = m_rise | (nv & ~ov);
    m_fall = m_fall | (~nv & ov);
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  logic rdy_d = 0;
  always @(negedge clk) begin
    if (ready && !rdy_d && !write) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("rdata", rdata, exp_q.pop_front());
    end
    rdy_d <= ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    check_outs("rst");
    rstb = 1;
    repeat (10) @(posedge clk);
    #1;
    check_outs("armed");
    access(BASE + 0, 0, 0);
    access(BASE + 3, 0, 0);
    access(BASE + 4, 0, 0);

    access(BASE + 8 + 2, 1, 8'h0F);
    access(BASE + 8 + 1, 1, 8'hA5);
    check_outs("p1_wr");
    chk("p1_oe_pins", pin_oe[15:8], 8'h0F);
    chk("p1_o_pins", pin_o[15:8], 8'hA5);
    chk("p0_o_pins", pin_o[7:0], 8'h00);
    access(BASE + 8 + 2, 0, 0);
    access(BASE + 8 + 1, 0, 0);
    access(BASE + 1, 0, 0);

    // rising edge on port0 bit2 with exact flag latency
    set_pins(16'h0000);
    access(BASE + 4, 1, 8'hFF);
    access(BASE + 5, 1, 8'h04);
    check_outs("ie");
    @(posedge clk); #1;
    pin_i = 16'h0004;
    @(posedge clk); @(negedge clk); chk("edge_k", irq, 0);
    @(posedge clk); @(negedge clk); chk("edge_k1", irq, 0);
    @(posedge clk); @(negedge clk); chk("edge_k2", irq, 1);
    m_rise[0] = m_rise[0] | 8'h04;
    access(BASE + 3, 0, 0);
    access(BASE + 3, 1, 8'h04);
    check_outs("w1c");
    access(BASE + 3, 0, 0);

    // edge on bit0 lands on the same edge as its w1c
    @(posedge clk); #1;
    pin_i = 16'h0005;
    @(posedge clk);
    access(BASE + 3, 1, 8'h01);
    m_rise[0] = m_rise[0] | 8'h01;
    access(BASE + 3, 0, 0);

    // outside the window
    access(BASE - 1, 0, 0);
    access(BASE + 8*NPORT, 0, 0);
    access(BASE - 7, 1, 8'hFF);
    access(BASE + 8*NPORT + 1, 1, 8'hFF);
    check_outs("miss");
    access(BASE + 1, 0, 0);

    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 7) == 0) set_pins(16'($urandom));
      else access(24'(BASE + 8*$urandom_range(0, NPORT-1) + $urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom));
      check_outs("rnd");
    end

    // reset while a write is being acknowledged
    @(posedge clk); #1;
    valid = 1; write = 1; addr = BASE + 1; wdata = 8'h5A;
    @(posedge clk); #1;
    chk("mid_ready", ready, 1);
    chk("mid_pin_o", pin_o[7:0], 8'h5A);
    rstb = 0;
    #1;
    chk("abort_ready", ready, 0);
    chk("abort_pin_o", pin_o, 0);
    m_reset();
    valid = 0;
    repeat (2) @(posedge clk);
    #1 rstb = 1;
    repeat (10) @(posedge clk);
    #1;
    check_outs("rerst");
    access(BASE + 1, 1, 8'h3C);
    check_outs("after");
    access(BASE + 1, 0, 0);

    repeat (3) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
